shot_controller: RTL and testbench

- Owns the player's single shot.
- Spawns the shot from the cannon on a fire press and moves it up one step per frame tick.
- After each step, scans the 15-alien grid sequentially for a collision and emits kill/score pulses.
- Sits directly upstream of the frame renderer: shotX/shotY drive its shot inputs; killMask and scorePulse feed the alien-state and score logic.

---
 rtl/shot_controller.sv | 191 +++++++++++++++++++
 tb/tb_shot_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// shot_controller: owns the player's single shot.
// A rising edge on fire (with over low) spawns the shot above the cannon.
// Each frame tick then lifts the shot by SHOT_STEP pixels and starts a scan
// of the alien grid, one alien per clock, for a collision.
// Optional build macro ROW_SCORE_EN: when defined, a hit is worth more the
// higher the alien row (top row = ROWS points). Otherwise every hit is worth 1.
// The port list and timing do not change with the macro.
module shot_controller #(
  parameter int COLS       = 5,
  parameter int ROWS       = 3,
  parameter int ALIEN_W    = 8,
  parameter int ALIEN_H    = 6,
  parameter int COL_PITCH  = 12,
  parameter int ROW_PITCH  = 10,
  parameter int SHOT_STEP  = 2,
  parameter int CANNON_MID = 3,
  parameter int PARK_Y     = 127
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   fire,
  input  logic                   over,
  input  logic [7:0]             cannonX,
  input  logic [7:0]             cannonY,
  input  logic [7:0]             alienX,
  input  logic [7:0]             alienY,
  input  logic [COLS*ROWS-1:0]   alive,
  output logic [7:0]             shotX,
  output logic [7:0]             shotY,
  output logic                   shotActive,
  output logic [COLS*ROWS-1:0]   killMask,
  output logic                   scorePulse,
  output logic [3:0]             scoreAdd
);

  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [N-1:0]  ONE_HOT0 = N'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [7:0]    PARK_Y8  = 8'(PARK_Y);
  localparam logic [7:0]    STEP8    = 8'(SHOT_STEP);

  // Kill/score output semantics: there is no ready. killMask, scorePulse and
  // scoreAdd are a single-cycle registered pulse; a consumer must capture
  // them in the one clock that scorePulse is high. killMask is one-hot while
  // scorePulse is high and all-zero otherwise. scoreAdd is zero when idle.

  typedef enum logic [1:0] {
    IDLE,   // no shot in flight; waiting for a fire edge
    FLY,    // shot in flight; waiting for a frame tick
    CHECK,  // scanning alien idx for a collision, one per clock
    HIT     // kill pulse is on the outputs this cycle
  } state_t;

  state_t        state;
  logic          fire_q;
  logic          tick_pend;
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          fire_edge;
  logic          take_tick;
  logic [8:0]    ax;
  logic [8:0]    ay;
  logic [8:0]    sx;
  logic [8:0]    sy;
  logic          cell_hit;
  logic [3:0]    row_score;

  assign fire_edge = fire & ~fire_q;
  assign take_tick = tick | tick_pend;

  // Collision test for the alien at (col,row); 9-bit geometry so that
  // grid positions near the right/bottom edge never wrap around.
  always_comb begin
    ax = {1'b0, alienX} + 9'(int'(col) * COL_PITCH);
    ay = {1'b0, alienY} + 9'(int'(row) * ROW_PITCH);
    sx = {1'b0, shotX};
    sy = {1'b0, shotY};
    cell_hit = alive[idx]
             && (sx >= ax) && (sx <= ax + 9'(ALIEN_W - 1))
             && (sy >= ay) && (sy <= ay + 9'(ALIEN_H - 1));
  end

`ifdef ROW_SCORE_EN
  // Higher rows (lower row index) are worth more points.
  assign row_score = 4'(ROWS) - 4'(row);
`else
  // Flat scoring: every alien is worth one point.
  assign row_score = 4'd1;
`endif

  // Shot FSM: spawn, per-tick climb, grid scan and kill pulse generation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shotX      <= 8'd0;
      shotY      <= PARK_Y8;
      shotActive <= 1'b0;
      killMask   <= '0;
      scorePulse <= 1'b0;
      scoreAdd   <= 4'd0;
      fire_q     <= 1'b0;
      tick_pend  <= 1'b0;
      idx        <= '0;
      col        <= '0;
      row        <= '0;
    end else begin
      fire_q     <= fire;
      killMask   <= '0;
      scorePulse <= 1'b0;
      scoreAdd   <= 4'd0;
      if (over) begin
        // Game over wins over everything, including a scan about to hit.
        state      <= IDLE;
        shotX      <= 8'd0;
        shotY      <= PARK_Y8;
        shotActive <= 1'b0;
        tick_pend  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tick_pend <= 1'b0;
            if (fire_edge) begin
              shotX      <= cannonX + 8'(CANNON_MID);
              shotY      <= cannonY - 8'd1;
              shotActive <= 1'b1;
              state      <= FLY;
            end
          end
          FLY: begin
            if (take_tick) begin
              tick_pend <= 1'b0;
              if (shotY < STEP8) begin
                // Shot left the top of the screen without hitting anything.
                shotX      <= 8'd0;
                shotY      <= PARK_Y8;
                shotActive <= 1'b0;
                state      <= IDLE;
              end else begin
                shotY <= shotY - STEP8;
                idx   <= '0;
                col   <= '0;
                row   <= '0;
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            // A tick during the scan is remembered (only one) for FLY.
            if (tick) tick_pend <= 1'b1;
            if (cell_hit) begin
              killMask   <= ONE_HOT0 << idx;
              scorePulse <= 1'b1;
              scoreAdd   <= row_score;
              shotX      <= 8'd0;
              shotY      <= PARK_Y8;
              shotActive <= 1'b0;
              state      <= HIT;
            end else if (idx == LAST_IDX) begin
              state <= FLY;
            end else begin
              idx <= idx + IW'(1);
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
          HIT: begin
            // Pulse is visible this cycle; any pending tick dies with the shot.
            tick_pend <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_controller.sv
// Testbench for shot_controller: directed scenarios, a behavioural model of
// the shot checked every clock, and hand-computed literal expectations.
module tb_shot_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        fire = 1'b0;
  logic        over = 1'b0;
  logic [7:0]  cannonX = 8'd0;
  logic [7:0]  cannonY = 8'd0;
  logic [7:0]  alienX = 8'd0;
  logic [7:0]  alienY = 8'd0;
  logic [14:0] alive = 15'd0;
  logic [7:0]  shotX;
  logic [7:0]  shotY;
  logic        shotActive;
  logic [14:0] killMask;
  logic        scorePulse;
  logic [3:0]  scoreAdd;

  int checks = 0;
  int passes = 0;

  int          pulse_count = 0;
  logic [14:0] last_kill = '0;
  logic [3:0]  last_add = '0;

  // ---------------- clock ----------------
  always #10 clock = ~clock;

  shot_controller dut (
    .clock(clock), .reset(reset), .tick(tick), .fire(fire), .over(over),
    .cannonX(cannonX), .cannonY(cannonY), .alienX(alienX), .alienY(alienY),
    .alive(alive), .shotX(shotX), .shotY(shotY), .shotActive(shotActive),
    .killMask(killMask), .scorePulse(scorePulse), .scoreAdd(scoreAdd)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Shot described as position + "in flight" + "which alien is being looked at
  // (-1 = none)" + "a kill is being shown this cycle".
  int          m_x = 0;
  int          m_y = 127;
  bit          m_active = 0;
  int          m_scan = -1;
  bit          m_pend = 0;
  bit          m_showing_kill = 0;
  bit          m_fire_prev = 0;
  logic [14:0] m_kill = '0;
  bit          m_pulse = 0;
  int          m_add = 0;

  function automatic bit alien_hit(int k);
    int ax, ay;
    ax = int'(alienX) + (k % 5) * 12;
    ay = int'(alienY) + (k / 5) * 10;
    return alive[k] && m_x >= ax && m_x <= ax + 7 && m_y >= ay && m_y <= ay + 5;
  endfunction

  function automatic int points(int k);
`ifdef ROW_SCORE_EN
    return 3 - k / 5;
`else
    return 1 + 0 * k;
`endif
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_x = 0; m_y = 127; m_active = 0; m_scan = -1; m_pend = 0;
      m_showing_kill = 0; m_fire_prev = 0; m_kill = '0; m_pulse = 0; m_add = 0;
    end else begin
      bit fe;
      fe = fire && !m_fire_prev;
      m_fire_prev = fire;
      m_kill = '0; m_pulse = 0; m_add = 0;
      if (over) begin
        m_x = 0; m_y = 127; m_active = 0; m_scan = -1; m_pend = 0; m_showing_kill = 0;
      end else if (m_showing_kill) begin
        m_showing_kill = 0; m_pend = 0;
      end else if (!m_active) begin
        m_pend = 0;
        if (fe) begin
          m_x = (int'(cannonX) + 3) % 256;
          m_y = (int'(cannonY) + 255) % 256;
          m_active = 1;
        end
      end else if (m_scan < 0) begin
        if (tick || m_pend) begin
          m_pend = 0;
          if (m_y < 2) begin
            m_x = 0; m_y = 127; m_active = 0;
          end else begin
            m_y = m_y - 2;
            m_scan = 0;
          end
        end
      end else begin
        if (tick) m_pend = 1;
        if (alien_hit(m_scan)) begin
          m_kill = 15'(1) << m_scan;
          m_pulse = 1;
          m_add = points(m_scan);
          m_x = 0; m_y = 127; m_active = 0;
          m_showing_kill = 1;
          m_scan = -1;
        end else if (m_scan == 14) begin
          m_scan = -1;
        end else begin
          m_scan++;
        end
      end
    end
  end

  // ---------------- scoreboard compare (every clock) ----------------
  always @(posedge clock) begin
    #1;
    check("outputs", {shotX, shotY, shotActive, killMask, scorePulse, scoreAdd},
          {8'(m_x), 8'(m_y), m_active, m_kill, m_pulse, 4'(m_add)});
    if (scorePulse) begin
      pulse_count++;
      last_kill = killMask;
      last_add  = scoreAdd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fire_press();
    @(negedge clock); fire = 1'b1;
    @(negedge clock); fire = 1'b0;
  endtask

  task automatic tick_scan();
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    repeat (16) @(negedge clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    check("reset_shotY", shotY, 8'd127);
    check("reset_active", shotActive, 1'b0);
    reset = 1'b1;

    // Spawn and climb.
    cannonX = 8'd40; cannonY = 8'd110; alienX = 8'd30; alienY = 8'd20; alive = 15'h0000;
    fire_press();
    check("spawn_x", shotX, 8'd43);
    check("spawn_y", shotY, 8'd109);
    check("spawn_active", shotActive, 1'b1);
    repeat (3) tick_scan();
    check("three_ticks_y", shotY, 8'd103);

    // Asynchronous reset mid-flight.
    @(posedge clock); #3 reset = 1'b0; #1;
    check("async_x", shotX, 8'd0);
    check("async_y", shotY, 8'd127);
    check("async_active", shotActive, 1'b0);
    check("async_kill", killMask, 15'h0000);
    @(negedge clock); reset = 1'b1;

    // Full grid: hit idx 11 at y=45.
    alive = 15'h7FFF; pulse_count = 0;
    fire_press();
    repeat (31) tick_scan();
    check("full_y47", shotY, 8'd47);
    check("full_no_pulse_yet", pulse_count, 0);
    tick_scan();
    check("full_pulses", pulse_count, 1);
    check("full_kill", last_kill, 15'h0800);
    check("full_add", last_add, 4'd1);
    check("full_parked", shotY, 8'd127);

    // idx 11 dead: pass y=45, hit idx 6 at y=35.
    alive = 15'h77FF; pulse_count = 0;
    fire_press();
    repeat (32) tick_scan();
    check("gap_y45", shotY, 8'd45);
    check("gap_no_pulse", pulse_count, 0);
    repeat (5) tick_scan();
    check("gap_pulses", pulse_count, 1);
    check("gap_kill", last_kill, 15'h0040);
`ifdef ROW_SCORE_EN
    check("gap_add", last_add, 4'd2);
`else
    check("gap_add", last_add, 4'd1);
`endif

    // Fire held: shot runs off the top, no re-fire until a fresh edge.
    alive = 15'h0000; pulse_count = 0;
    @(negedge clock); fire = 1'b1;
    repeat (54) tick_scan();
    check("held_y1", shotY, 8'd1);
    check("held_active", shotActive, 1'b1);
    tick_scan();
    check("held_parked_y", shotY, 8'd127);
    check("held_parked_active", shotActive, 1'b0);
    check("held_no_pulse", pulse_count, 0);
    repeat (5) @(negedge clock);
    check("held_no_refire", shotActive, 1'b0);
    fire = 1'b0;
    @(negedge clock); fire = 1'b1;
    @(negedge clock);
    check("refire_y", shotY, 8'd109);
    fire = 1'b0;

    // Game over 4 clocks into a scan that would hit idx 6.
    alienX = 8'd31; alienY = 8'd97; alive = 15'h7FFF; pulse_count = 0;
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    repeat (3) @(negedge clock);
    over = 1'b1;
    repeat (12) @(negedge clock);
    check("over_parked", shotY, 8'd127);
    check("over_no_pulse", pulse_count, 0);
    fire_press();
    check("over_fire_ignored", shotActive, 1'b0);
    over = 1'b0;
    @(negedge clock);
    fire_press();
    check("after_over_spawn", shotY, 8'd109);

    // Game over on the very cycle idx 0 would be hit.
    alienX = 8'd40; alienY = 8'd105;
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0; over = 1'b1;
    repeat (4) @(negedge clock);
    check("over0_parked", shotActive, 1'b0);
    check("over0_no_pulse", pulse_count, 0);
    over = 1'b0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
